// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the instruction fetch memory.
//   imem_state_t   : controller state (LOAD while the image is being written, RUN when serving fetches)
//   NOP            : instruction value returned alongside an error response
//   assemble_instr : packs fetched byte lanes into an instruction word, in either byte order
package instr_mem_pkg;

    typedef enum logic {LOAD, RUN} imem_state_t;

    localparam int NOP = 0;

    // Widest instruction the helper supports; callers zero-pad their lanes to this width.
    localparam int MAX_INSTR_BYTES = 8;
    localparam int MAX_IW          = 8 * MAX_INSTR_BYTES;

    // lanes[8*i +: 8] holds byte m[pc+i]. Big-endian puts m[pc] in the top byte of the
    // nbytes-wide word; little-endian keeps m[pc] in the bottom byte.
    function automatic logic [MAX_IW-1:0] assemble_instr(input logic [MAX_IW-1:0] lanes,
                                                         input int               nbytes,
                                                         input logic             big_endian);
        logic [MAX_IW-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_INSTR_BYTES; i++) begin
            if (i < nbytes) begin
                if (big_endian) r[8*(nbytes-1-i) +: 8] = lanes[8*i +: 8];
                else            r[8*i +: 8]            = lanes[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/instr_byte_ram.sv
// Byte-wide storage for the instruction image.
//   clk   : rising-edge clock for the write port
//   we    : write wdata to byte waddr (addresses at or beyond DEPTH_BYTES are dropped)
//   waddr : write byte address
//   wdata : write byte
//   raddr : first byte of the combinational read window
//   rdata : INSTR_BYTES bytes, lane i = m[raddr+i]; lanes past the end of storage read 0
// Contents have no reset so the image survives a controller reset.
module instr_byte_ram
    import instr_mem_pkg::*;
#(
    parameter int DEPTH_BYTES = 512,
    parameter int INSTR_BYTES = 4,
    parameter int AW          = 9
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic [7:0]               wdata,
    input  logic [AW-1:0]            raddr,
    output logic [8*INSTR_BYTES-1:0] rdata
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH_BYTES);

    logic [7:0] mem [DEPTH_BYTES];

    always_ff @(posedge clk) begin
        if (we && ({1'b0, waddr} < DEPTH_W)) begin
            mem[waddr] <= wdata;
        end
    end

    // One extra address bit keeps raddr+i from wrapping back into valid storage.
    for (genvar i = 0; i < INSTR_BYTES; i++) begin : g_rd
        logic [AW:0] a;
        assign a = {1'b0, raddr} + (AW+1)'(i);
        assign rdata[8*i +: 8] = (a < DEPTH_W) ? mem[a[AW-1:0]] : 8'h00;
    end

endmodule

// File: rtl/instr_fetch_mem.sv
// Byte-addressed instruction memory with a valid/ready fetch port (1-cycle latency,
// one fetch per cycle) and a byte load port for programming the image.
//   clk           : rising-edge clock
//   rst           : asynchronous active-low reset (memory contents are kept)
//   ld_en/ld_addr/ld_data : byte write, accepted in either state
//   ld_done       : leave LOAD for RUN
//   loading       : high while in LOAD
//   req_valid/req_ready/req_pc : fetch request, byte address
//   resp_valid/resp_ready      : response handshake, response held until accepted
//   resp_instr    : fetched instruction, NOP on error
//   resp_err      : out-of-range (or misaligned when trapping) fetch
//   resp_misalign : misalignment trap flag
//   fetch_cnt     : saturating count of accepted requests
// Build option: define INSTR_MEM_MISALIGN_TRAP_EN to reject fetches whose pc is not a
// multiple of INSTR_BYTES; otherwise unaligned fetches return the bytes at pc.
//
// state | meaning
// LOAD  | image being programmed, fetches blocked
// RUN   | fetches served, ld_done ignored
module instr_fetch_mem
    import instr_mem_pkg::*;
#(
    parameter int DEPTH_BYTES = 512,
    parameter int INSTR_BYTES = 4,
    parameter int BIG_ENDIAN  = 1,
    parameter int BOOT_LOAD   = 1,
    parameter int CNT_W       = 16,
    localparam int AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1,
    localparam int IW = 8 * INSTR_BYTES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [7:0]       ld_data,
    input  logic             ld_done,
    output logic             loading,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_pc,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [IW-1:0]    resp_instr,
    output logic             resp_err,
    output logic             resp_misalign,
    output logic [CNT_W-1:0] fetch_cnt
);

    localparam imem_state_t RESET_STATE = (BOOT_LOAD != 0) ? LOAD : RUN;

    imem_state_t state, next_state;

    logic              accept;
    logic [32:0]       last_byte;
    logic              out_of_range;
    logic              misalign;
    logic [IW-1:0]     rd_lanes;
    logic [MAX_IW-1:0] asm_full;
    logic [IW-1:0]     fetched;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RESET_STATE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        loading    = 1'b0;
        case (state)
            LOAD: begin
                loading = 1'b1;
                if (ld_done) next_state = RUN;
            end
            RUN: ;
            default: next_state = RESET_STATE;
        endcase
    end

    // Loads take priority over fetches so the read window never sees a same-cycle write.
    assign req_ready = (state == RUN) && !ld_en && (!resp_valid || resp_ready);
    assign accept    = req_valid && req_ready;

    // 33-bit sum so a pc near 2^32 cannot wrap back into range.
    assign last_byte    = {1'b0, req_pc} + 33'(INSTR_BYTES - 1);
    assign out_of_range = last_byte >= 33'(DEPTH_BYTES);

`ifdef INSTR_MEM_MISALIGN_TRAP_EN
    assign misalign = (req_pc % 32'(INSTR_BYTES)) != 32'd0;
`else
    assign misalign = 1'b0;
`endif

    instr_byte_ram #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .INSTR_BYTES (INSTR_BYTES),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ld_en),
        .waddr (ld_addr),
        .wdata (ld_data),
        .raddr (req_pc[AW-1:0]),
        .rdata (rd_lanes)
    );

    assign asm_full = assemble_instr(MAX_IW'(rd_lanes), INSTR_BYTES, BIG_ENDIAN != 0);
    assign fetched  = asm_full[IW-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid    <= 1'b0;
            resp_instr    <= '0;
            resp_err      <= 1'b0;
            resp_misalign <= 1'b0;
        end else if (accept) begin
            resp_valid    <= 1'b1;
            resp_instr    <= (out_of_range || misalign) ? IW'(NOP) : fetched;
            resp_err      <= out_of_range || misalign;
            resp_misalign <= misalign;
        end else if (resp_ready) begin
            resp_valid    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt <= '0;
        end else if (accept && (fetch_cnt != {CNT_W{1'b1}})) begin
            fetch_cnt <= fetch_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_instr_fetch_mem.sv
module tb_instr_fetch_mem;

    localparam int DEPTH = 512;
    localparam int IB    = 4;

    logic        clk;
    logic        rst;
    logic        ld_en;
    logic [8:0]  ld_addr;
    logic [7:0]  ld_data;
    logic        ld_done;
    logic        loading;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_instr;
    logic        resp_err;
    logic        resp_misalign;
    logic [15:0] fetch_cnt;

    instr_fetch_mem dut (
        .clk           (clk),
        .rst           (rst),
        .ld_en         (ld_en),
        .ld_addr       (ld_addr),
        .ld_data       (ld_data),
        .ld_done       (ld_done),
        .loading       (loading),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_pc        (req_pc),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_instr    (resp_instr),
        .resp_err      (resp_err),
        .resp_misalign (resp_misalign),
        .fetch_cnt     (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: byte image plus the expected response register contents.
    logic [7:0]  mem_m [DEPTH];
    logic        m_load;
    logic        m_valid;
    logic [31:0] m_instr;
    logic        m_err;
    logic        m_mis;
    logic [15:0] m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic predict(input logic [31:0] pc, output logic [31:0] instr,
                           output logic err, output logic mis);
        longint last;
        last = longint'(pc) + longint'(IB - 1);
`ifdef INSTR_MEM_MISALIGN_TRAP_EN
        mis = (pc % IB) != 0;
`else
        mis = 1'b0;
`endif
        err = (last >= DEPTH) || mis;
        if (err) instr = 32'h0;
        else     instr = {mem_m[pc], mem_m[pc+1], mem_m[pc+2], mem_m[pc+3]};
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic cycle();
        logic        exp_rdy;
        logic        acc;
        logic [31:0] e_i;
        logic        e_e, e_m;
        #1;
        exp_rdy = !m_load && !ld_en && (!m_valid || resp_ready);
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("loading", 64'(loading), 64'(m_load));
        acc = req_valid && exp_rdy;
        if (acc) predict(req_pc, e_i, e_e, e_m);
        if (ld_en) mem_m[ld_addr] = ld_data;
        if (acc) begin
            m_valid = 1'b1;
            m_instr = e_i;
            m_err   = e_e;
            m_mis   = e_m;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else if (resp_ready) begin
            m_valid = 1'b0;
        end
        if (m_load && ld_done) m_load = 1'b0;
        @(posedge clk);
        #1;
        chk("resp_valid", 64'(resp_valid), 64'(m_valid));
        if (m_valid) begin
            chk("resp_instr", 64'(resp_instr), 64'(m_instr));
            chk("resp_err", 64'(resp_err), 64'(m_err));
            chk("resp_misalign", 64'(resp_misalign), 64'(m_mis));
        end
        chk("fetch_cnt", 64'(fetch_cnt), 64'(m_cnt));
    endtask

    task automatic idle_inputs();
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        ld_done   = 1'b0;
        req_valid = 1'b0;
        req_pc    = '0;
        resp_ready = 1'b1;
    endtask

    task automatic fetch(input logic [31:0] pc);
        req_valid = 1'b1;
        req_pc    = pc;
        cycle();
        req_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] held;
        logic [15:0] cnt0;
        logic [7:0]  saved;
        int          sel;

        idle_inputs();
        req_valid = 1'b1;
        rst = 1'b0;
        m_load = 1'b1; m_valid = 1'b0; m_cnt = '0;
        m_instr = '0; m_err = 1'b0; m_mis = 1'b0;
        #12;
        // Reset state
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_resp_instr", 64'(resp_instr), 64'(0));
        chk("rst_resp_err", 64'(resp_err), 64'(0));
        chk("rst_misalign", 64'(resp_misalign), 64'(0));
        chk("rst_fetch_cnt", 64'(fetch_cnt), 64'(0));
        chk("rst_loading", 64'(loading), 64'(1));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        cycle();            // fetch request ignored while loading
        req_valid = 1'b0;

        // Program the whole image with random bytes, then the known word at 0..3.
        for (int a = 0; a < DEPTH; a++) begin
            ld_en = 1'b1; ld_addr = 9'(a); ld_data = 8'($urandom_range(0, 255));
            cycle();
        end
        for (int a = 0; a < 4; a++) begin
            ld_en = 1'b1; ld_addr = 9'(a);
            case (a)
                0: ld_data = 8'h20;
                1: ld_data = 8'h01;
                2: ld_data = 8'h00;
                default: ld_data = 8'h05;
            endcase
            cycle();
        end
        ld_en = 1'b0;
        ld_done = 1'b1;
        cycle();
        ld_done = 1'b0;
        chk("t1_run", 64'(loading), 64'(0));

        // 1: first fetch
        fetch(32'd0);
        chk("t1_instr", 64'(resp_instr), 64'h20010005);
        chk("t1_err", 64'(resp_err), 64'(0));

        // 2: back-to-back
        cnt0 = fetch_cnt;
        resp_ready = 1'b1;
        req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_pc = 32'(4 * (k + 1) - 4);
            cycle();
            chk("t2_valid", 64'(resp_valid), 64'(1));
        end
        chk("t2_cnt3", 64'(fetch_cnt - cnt0), 64'(3));

        // 3: stall, then release
        resp_ready = 1'b0;
        req_pc = 32'd12;
        held = resp_instr;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t3_stable", 64'(resp_instr), 64'(held));
        end
        resp_ready = 1'b1;
        #1;
        chk("t3_release_ready", 64'(req_ready), 64'(1));
        cycle();
        req_valid = 1'b0;

        // 4: range boundaries
        fetch(32'd508);
        chk("t4_508_err", 64'(resp_err), 64'(0));
        fetch(32'd510);
        chk("t4_510_err", 64'(resp_err), 64'(1));
        chk("t4_510_instr", 64'(resp_instr), 64'(0));
        fetch(32'd509);
        fetch(32'hFFFF_FFFC);
        chk("t4_nowrap_err", 64'(resp_err), 64'(1));

        // 5: unaligned pc
        fetch(32'd2);
`ifdef INSTR_MEM_MISALIGN_TRAP_EN
        chk("t5_err", 64'(resp_err), 64'(1));
        chk("t5_mis", 64'(resp_misalign), 64'(1));
`else
        chk("t5_err", 64'(resp_err), 64'(0));
        chk("t5_instr", 64'(resp_instr), 64'({8'h00, 8'h05, mem_m[4], mem_m[5]}));
`endif

        // 6: load in RUN blocks fetches; reset mid-stall
        req_valid = 1'b1; req_pc = 32'd16;
        ld_en = 1'b1; ld_addr = 9'd100; ld_data = 8'hA5;
        #1;
        chk("t6_ld_blocks", 64'(req_ready), 64'(0));
        cycle();
        ld_en = 1'b0;
        req_valid = 1'b0;
        fetch(32'd100);
        chk("t6_new_byte", 64'(resp_instr[31:24]), 64'(8'hA5));
        fetch(32'd200);
        saved = mem_m[200];
        resp_ready = 1'b0;
        cycle();
        #2;
        rst = 1'b0;
        #1;
        chk("t6_async_valid", 64'(resp_valid), 64'(0));
        chk("t6_async_cnt", 64'(fetch_cnt), 64'(0));
        chk("t6_async_loading", 64'(loading), 64'(1));
        m_valid = 1'b0; m_cnt = '0; m_load = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        resp_ready = 1'b1;
        ld_done = 1'b1;
        cycle();
        ld_done = 1'b0;
        fetch(32'd200);
        chk("t6_mem_kept", 64'(resp_instr[31:24]), 64'(saved));
        fetch(32'd100);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            ld_en   = ($urandom_range(0, 5) == 0);
            ld_addr = 9'($urandom_range(0, DEPTH - 1));
            ld_data = 8'($urandom_range(0, 255));
            ld_done = ($urandom_range(0, 15) == 0);
            req_valid  = ($urandom_range(0, 3) != 0);
            resp_ready = ($urandom_range(0, 3) != 0);
            sel = int'($urandom_range(0, 9));
            if (sel < 6)      req_pc = 32'($urandom_range(0, 127) * 4);
            else if (sel < 8) req_pc = 32'($urandom_range(0, 520));
            else              req_pc = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
            cycle();
        end

        idle_inputs();
        cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
